counter_stim_gen: RTL and testbench

//  Transmit side of the two-channel counter interface (dn_reset/en/sel): turns a pair of

---
 rtl/counter_stim_gen.sv | 205 ++++++++++++++++++++
 tb/tb_counter_stim_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_stim_gen.sv
// -----------------------------------------------------------------------------
// counter_stim_gen
//
// Transmit side of the two-channel counter interface (dn_reset/en/sel). Given a
// pair of target values it produces the en/sel pulse stream that leaves a freshly
// cleared downstream counter holding output0 = cnt0_in and output1 = cnt1_in.
//
// Sequence: IDLE -> CLR -> SEL1 -> SEL0 -> DONE -> IDLE
//   CLR  : one-cycle dn_reset, remaining loaded with the channel-1 pulse count
//   SEL1 : sel=1 pulses (channel 1 divides by 3 and needs 4 for its first step)
//   SEL0 : sel=0 pulses; must follow SEL1 since sel=1 pulses clear output0
//   DONE : one-cycle done pulse
//
// Parameters
//   W          width of the target values
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request, sampled only in IDLE
//   cnt0_in    channel-0 target (sel=0 pulses)
//   cnt1_in    channel-1 target (sel=1 pulses)
//   pause      in SEL1/SEL0: suppress en, hold remaining and state
//   abort      (CNTGEN_ABORT_EN only) drop back to IDLE from CLR/SEL1/SEL0
//   dn_reset   synchronous clear to the downstream counter
//   en         count enable to the downstream counter
//   sel        channel select to the downstream counter
//   busy       high in CLR, SEL1, SEL0
//   done       one-cycle completion pulse
//   remaining  pulses left in the current phase
//
// Configuration macro: CNTGEN_ABORT_EN adds the abort input. With the macro
// undefined the port does not exist and the abort path is absent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module counter_stim_gen #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] cnt0_in,
   input  logic [W-1:0] cnt1_in,
   input  logic         pause,
`ifdef CNTGEN_ABORT_EN
   input  logic         abort,
`endif
   output logic         dn_reset,
   output logic         en,
   output logic         sel,
   output logic         busy,
   output logic         done,
   output logic [W+1:0] remaining
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_SEL1,
      S_SEL0,
      S_DONE
   } state_t;

   state_t         state_q,     state_d;
   logic [W-1:0]   cnt0_q,      cnt0_d;
   logic [W+1:0]   remaining_q, remaining_d;
   logic           dn_reset_q,  dn_reset_d;
   logic           en_q,        en_d;
   logic           sel_q,       sel_d;
   logic           busy_q,      busy_d;
   logic           done_q,      done_d;

   // Channel-1 pulse count: 3*cnt1+1, or 0 when cnt1 is 0. W+2 bits holds the
   // largest value 3*(2^W-1)+1 without wrap.
   logic [W+1:0]   cnt1_ext;
   logic [W+1:0]   n1;

   assign cnt1_ext = {2'b00, cnt1_in};
   assign n1       = (cnt1_in == '0) ? '0
                   : (cnt1_ext << 1) + cnt1_ext + (W+2)'(1);

   logic           abort_hit;
`ifdef CNTGEN_ABORT_EN
   assign abort_hit = abort && ((state_q == S_CLR) || (state_q == S_SEL1) ||
                                (state_q == S_SEL0));
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d     = state_q;
      cnt0_d      = cnt0_q;
      remaining_d = remaining_q;
      dn_reset_d  = 1'b0;
      en_d        = 1'b0;
      sel_d       = sel_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            sel_d       = 1'b0;
            busy_d      = 1'b0;
            remaining_d = '0;
            if (start) begin
               state_d     = S_CLR;
               cnt0_d      = cnt0_in;
               remaining_d = n1;
               dn_reset_d  = 1'b1;
               busy_d      = 1'b1;
            end
         end

         S_CLR: begin
            state_d = S_SEL1;
            sel_d   = 1'b1;
         end

         S_SEL1: begin
            if (!pause) begin
               if (remaining_q != '0) begin
                  en_d        = 1'b1;
                  remaining_d = remaining_q - (W+2)'(1);
               end else begin
                  // Zero-detect cycle: switch channels with en low.
                  state_d     = S_SEL0;
                  sel_d       = 1'b0;
                  remaining_d = {2'b00, cnt0_q};
               end
            end
         end

         S_SEL0: begin
            if (!pause) begin
               if (remaining_q != '0) begin
                  en_d        = 1'b1;
                  remaining_d = remaining_q - (W+2)'(1);
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         S_DONE: begin
            state_d     = S_IDLE;
            remaining_d = '0;
         end

         default: begin
            state_d     = S_IDLE;
            sel_d       = 1'b0;
            busy_d      = 1'b0;
            remaining_d = '0;
         end
      endcase

      // Abort wins over pause and suppresses the done pulse.
      if (abort_hit) begin
         state_d     = S_IDLE;
         dn_reset_d  = 1'b0;
         en_d        = 1'b0;
         sel_d       = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         remaining_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt0_q      <= '0;
         remaining_q <= '0;
         dn_reset_q  <= 1'b0;
         en_q        <= 1'b0;
         sel_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // value of its inputs, independent of statement order.
         state_q     <= state_d;
         cnt0_q      <= cnt0_d;
         remaining_q <= remaining_d;
         dn_reset_q  <= dn_reset_d;
         en_q        <= en_d;
         sel_q       <= sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign dn_reset  = dn_reset_q;
   assign en        = en_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;

endmodule

// File: tb/tb_counter_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_counter_stim_gen
//
// Stimulus issues transactions (directed and random, with random pause and
// mid-transaction start pulses) and pushes the expected outcome of each into a
// scoreboard queue. A monitor drives a behavioural model of the downstream
// counter from the sampled en/sel/dn_reset stream and, on every done pulse,
// pops the queue and compares pulse counts, busy length and the final counter
// values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_counter_stim_gen;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] cnt0_in;
   logic [W-1:0] cnt1_in;
   logic         pause;
`ifdef CNTGEN_ABORT_EN
   logic         abort;
`endif
   logic         dn_reset;
   logic         en;
   logic         sel;
   logic         busy;
   logic         done;
   logic [W+1:0] remaining;

   always #5 clk = ~clk;

   counter_stim_gen #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cnt0_in   (cnt0_in),
      .cnt1_in   (cnt1_in),
      .pause     (pause),
`ifdef CNTGEN_ABORT_EN
      .abort     (abort),
`endif
      .dn_reset  (dn_reset),
      .en        (en),
      .sel       (sel),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   typedef struct {
      int en1;
      int en0;
      int busy_cycles;
      int out0;
      int out1;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dn_reset"},  dn_reset,  0);
      check({tag, "_en"},        en,        0);
      check({tag, "_sel"},       sel,       0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_done"},      done,      0);
      check({tag, "_remaining"}, remaining, 0);
   endtask

   // Downstream counter model plus observed-stream accumulators.
   int   m_en1, m_en0, m_busy, m_p1, m_out0;
   exp_t m_e;

   always @(negedge clk) begin
      if (reset) begin
         if (dn_reset) begin
            m_en1  = 0;
            m_en0  = 0;
            m_busy = busy ? 1 : 0;
            m_p1   = 0;
            m_out0 = 0;
         end else begin
            if (busy) m_busy++;
            if (en && sel) begin
               m_en1++;
               m_p1++;
               m_out0 = 0;
            end else if (en) begin
               m_en0++;
               m_out0++;
            end
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               m_e = sb_q.pop_front();
               check("sel1_pulses", m_en1,  m_e.en1);
               check("sel0_pulses", m_en0,  m_e.en0);
               check("busy_cycles", m_busy, m_e.busy_cycles);
               check("model_out0",  m_out0, m_e.out0);
               // Channel 1 steps on its 4th pulse, then every 3rd.
               check("model_out1",  (m_p1 == 0) ? 0 : (m_p1 - 1) / 3, m_e.out1);
            end
         end
      end
   end

   // Remaining count after c consumed (non-paused) phase edges.
   function automatic int rem_at(input int c, input int n1, input int c0);
      return (c <= n1) ? (n1 - c) : (c0 - (c - n1 - 1));
   endfunction

   // kill_kind: 0 = async reset, 1 = abort; kill_at < 0 means run to completion.
   task automatic run_txn(input int c1, input int c0, input bit rnd,
                          input logic [63:0] pmask, input int kill_at,
                          input int kill_kind);
      int   n1;
      int   total;
      int   c;
      int   idx;
      bit   prev_p;
      bit   pq[$];
      exp_t e;

      n1    = (c1 == 0) ? 0 : 3 * c1 + 1;
      total = n1 + 1 + c0 + 1;
      c     = 0;
      idx   = 0;
      while (c < total) begin
         bit p;
         if (rnd) p = (pq.size() < 4 * total + 64) && ($urandom_range(0, 3) == 0);
         else     p = (idx < 64) ? pmask[idx] : 1'b0;
         idx++;
         pq.push_back(p);
         if (!p) c++;
      end
      e.en1         = n1;
      e.en0         = c0;
      e.busy_cycles = 1 + pq.size();
      e.out0        = c0;
      e.out1        = c1;
      sb_q.push_back(e);

      @(negedge clk);
      cnt1_in = W'(c1);
      cnt0_in = W'(c0);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      check("clr_dn_reset", dn_reset, 1);
      check("clr_remaining", remaining, n1);
      // Targets must have been latched; scramble the inputs.
      cnt1_in = W'($urandom_range(0, 65535));
      cnt0_in = W'($urandom_range(0, 65535));
      @(negedge clk);

      c      = 0;
      prev_p = 1'b0;
      foreach (pq[i]) begin
         check("remaining", remaining, rem_at(c, n1, c0));
         if (prev_p) check("paused_en", en, 0);
         if (c == kill_at) begin
            pause = 1'b0;
            start = 1'b0;
            if (kill_kind == 0) begin
               #2 reset = 1'b0;
               #1 check_all_zero("async_reset");
               void'(sb_q.pop_back());
               @(negedge clk);
               reset = 1'b1;
            end else begin
`ifdef CNTGEN_ABORT_EN
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               check_all_zero("abort");
               void'(sb_q.pop_back());
               @(negedge clk);
               check("abort_no_done", done, 0);
`endif
            end
            return;
         end
         pause  = pq[i];
         prev_p = pq[i];
         start  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         if (!pq[i]) c++;
         @(negedge clk);
      end
      pause = 1'b0;
      start = 1'b0;
      // DONE cycle now; one more edge back to IDLE.
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      pause   = 1'b0;
      cnt0_in = '0;
      cnt1_in = '0;
`ifdef CNTGEN_ABORT_EN
      abort   = 1'b0;
`endif
      #12;
      check_all_zero("reset_state");
      @(negedge clk);
      reset = 1'b1;

      run_txn(0, 5, 1'b0, 64'h0, -1, 0);
      run_txn(2, 3, 1'b0, 64'h0, -1, 0);
      run_txn(0, 0, 1'b0, 64'h0, -1, 0);
      // Pause four cycles after the second sel=1 pulse.
      run_txn(1, 4, 1'b0, 64'h3C, -1, 0);
      // Reset in SEL0 with remaining=2, then a 0/1 run.
      run_txn(1, 4, 1'b0, 64'h0, 7, 0);
      run_txn(0, 1, 1'b0, 64'h0, -1, 0);
`ifdef CNTGEN_ABORT_EN
      // Abort in SEL1 with remaining=5, restart two cycles later.
      run_txn(2, 9, 1'b0, 64'h0, 2, 1);
      run_txn(2, 3, 1'b0, 64'h0, -1, 0);
`endif
      repeat (25) begin
         run_txn($urandom_range(0, 12), $urandom_range(0, 12), 1'b1, 64'h0, -1, 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
